ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  - Execute stage plus EX/MEM pipeline register; consumes the ID/EX register outputs.
//  - Decodes ALU control from ALU_Op and funct bits, computes the ALU result, zero flag and branch target.
//  - Registers results and the WB/M control bits for the MEM stage.
//  - Supports stall (hold) and flush (bubble) from the hazard unit.
// PARAMETERS
//  XLEN  32  datapath width (pc, operands, results)
// PORTS
//  clock            in   1     single clock; all state updates on posedge
//  reset            in   1     synchronous, active-low (0 = clear on posedge)
//  stall            in   1     1 = hold all EX/MEM outputs this cycle
//  flush            in   1     1 = load a bubble (all control bits 0)
//  pc_address       in   XLEN  PC of the instruction in EX
//  read_data1       in   XLEN  rs1 value from ID/EX
//  read_data2       in   XLEN  rs2 value from ID/EX
//  imm              in   XLEN  sign-extended immediate; byte offset for branches
//  funct_inst_bits  in   4     {funct7[5], funct3}
//  rd               in   5     destination register
//  rs1, rs2         in   5     source register indices (used only with FWD_EN)
//  WB_reg_write, WB_mem_to_reg, M_branch, M_mem_read, M_mem_write  in  1 each  pass-through controls
//  EX_ALU_Op        in   2     00 add, 01 sub, 10 funct-decoded, 11 add
//  EX_ALU_Src       in   1     0 = operand B is rs2, 1 = operand B is imm
//  wb_rd            in   5     MEM/WB destination register (FWD_EN)
//  wb_reg_write     in   1     MEM/WB write enable (FWD_EN)
//  wb_data          in   XLEN  MEM/WB write-back value (FWD_EN)
//  out_alu_result   out  XLEN  registered ALU result
//  out_zero         out  1     registered (alu_result == 0)
//  out_write_data   out  XLEN  registered store data (rs2 after forwarding)
//  out_branch_target out XLEN  registered pc_address + imm (mod 2^XLEN)
//  out_rd           out  5     registered rd
//  WB_reg_write_out, WB_mem_to_reg_out, M_branch_out, M_mem_read_out, M_mem_write_out  out  1 each
// BEHAVIOUR
//  - Latency: 1 cycle from input to registered output; no internal state beyond the EX/MEM register.
//  - Reset (reset==0 at posedge): every output is 0. Reset overrides stall and flush.
//  - Priority per posedge: reset > flush > stall > normal load.
//  - Flush: all five control outputs become 0. Data/rd outputs load the current computed values.
//  - Stall: all outputs hold their previous values.
//  - Stall and flush together: flush wins.
//  - ALU control for EX_ALU_Op=10:
//      0000 add; 1000 sub (only if EX_ALU_Src==0, else add)
//      0111 and; 0110 or; 0100 xor
//      0001 sll; 0101 srl; 1101 sra (shift amount = B[4:0])
//      0010 slt (signed); 0011 sltu
//      any other code: add.
//  - Arithmetic wraps modulo 2^XLEN; no overflow flag.
//  - slt/sltu produce 1 or 0 zero-extended to XLEN.
//  - out_zero reflects the ALU result loaded in the same edge.
// CONFIGURATION
//  FWD_EN defined: forwarding mux on both operands A and B (B is pre-ALU_Src; it also feeds write_data).
//    - Priority 1, EX/MEM: WB_reg_write_out && out_rd!=0 && out_rd==rsX -> use out_alu_result.
//    - Priority 2, MEM/WB: wb_reg_write && wb_rd!=0 && wb_rd==rsX -> use wb_data.
//    - Otherwise use read_dataX. Register x0 is never forwarded.
//    - Load-use hazards are covered by an upstream stall/bubble, not detected here.
//  FWD_EN undefined: operands come straight from read_data1/2.
//    - rs1, rs2, wb_rd, wb_reg_write and wb_data are present but ignored.
// TESTING
//  1. reset=0 for 2 cycles with random inputs -> all outputs 0.
//  2. Op=10, funct=1000, Src=0, rs1val=5, rs2val=7 -> result 0xFFFFFFFE, zero=0.
//     Same with Src=1, imm=7 -> result 12.
//  3. Op=01, rs1val=rs2val=0x1234, pc=0x100, imm=-8, M_branch=1 -> zero=1, target 0xF8, M_branch_out=1.
//  4. Op=10, funct=1101, rs1val=0x80000000, imm=4, Src=1 -> result 0xF8000000.
//     funct=0010 with -1 vs 1 -> 1; funct=0011 -> 0.
//  5. Load valid op, then stall=1 for 3 cycles with changing inputs -> outputs unchanged.
//     Then stall=flush=1 -> control outputs 0.
//  6. FWD_EN: instr A writes x5 (result 9); next instr reads x5 and wb_rd=5, wb_data=3 -> EX/MEM value 9 is used.
//     rd=0 producers are never forwarded.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//
// Execute stage followed by the EX/MEM pipeline register. It takes the
// ID/EX register outputs and decodes the ALU operation from EX_ALU_Op and the
// funct bits. It then computes the ALU result, the zero flag and the branch
// target, and registers all of them together with the WB/M control bits for
// the MEM stage. The hazard unit can hold the register (stall) or load a
// bubble into it (flush).
//
// Optional feature macro: FWD_EN
//   When defined, operands A and B pass through a forwarding mux. The EX/MEM
//   register has first priority and the MEM/WB write-back has second.
//   Register x0 is never forwarded.
//   When undefined, rs1, rs2, wb_rd, wb_reg_write and wb_data are ignored.
//
// Ports
//   clock               clock, all state updates on the rising edge
//   reset               synchronous, active-low clear of every output
//   stall               hold all EX/MEM outputs
//   flush               load a bubble (control outputs 0, data still loads)
//   pc_address          PC of the instruction in EX
//   read_data1/2        rs1 / rs2 values from ID/EX
//   imm                 sign-extended immediate (byte offset for branches)
//   funct_inst_bits     {funct7[5], funct3}
//   rd, rs1, rs2        destination and source register indices
//   WB_*, M_*           pass-through control bits
//   EX_ALU_Op           00 add, 01 sub, 10 funct-decoded, 11 add
//   EX_ALU_Src          0 = operand B is rs2, 1 = operand B is imm
//   wb_rd/wb_reg_write/wb_data   MEM/WB write-back (forwarding only)
//   out_*               registered EX/MEM results
//   *_out               registered control bits
// ---------------------------------------------------------------------------
module ex_mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] pc_address,
    input  logic [XLEN-1:0] read_data1,
    input  logic [XLEN-1:0] read_data2,
    input  logic [XLEN-1:0] imm,
    input  logic [3:0]      funct_inst_bits,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic            WB_reg_write,
    input  logic            WB_mem_to_reg,
    input  logic            M_branch,
    input  logic            M_mem_read,
    input  logic            M_mem_write,
    input  logic [1:0]      EX_ALU_Op,
    input  logic            EX_ALU_Src,
    input  logic [4:0]      wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] out_alu_result,
    output logic            out_zero,
    output logic [XLEN-1:0] out_write_data,
    output logic [XLEN-1:0] out_branch_target,
    output logic [4:0]      out_rd,
    output logic            WB_reg_write_out,
    output logic            WB_mem_to_reg_out,
    output logic            M_branch_out,
    output logic            M_mem_read_out,
    output logic            M_mem_write_out
);

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU
    } alu_ctrl_e;

    alu_ctrl_e       alu_ctrl;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b_reg;
    logic [XLEN-1:0] operand_b;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] branch_target;
    logic [4:0]      shamt;

`ifdef FWD_EN
    // Operand forwarding. The instruction currently sitting in EX/MEM is
    // younger than the one in MEM/WB, so it wins when both target the same
    // register. Operand B is forwarded before the immediate select, so store
    // data also sees the forwarded value.
    always_comb begin
        operand_a = read_data1;
        if (WB_reg_write_out && (out_rd != 5'd0) && (out_rd == rs1)) begin
            operand_a = out_alu_result;
        end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs1)) begin
            operand_a = wb_data;
        end

        operand_b_reg = read_data2;
        if (WB_reg_write_out && (out_rd != 5'd0) && (out_rd == rs2)) begin
            operand_b_reg = out_alu_result;
        end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs2)) begin
            operand_b_reg = wb_data;
        end
    end
`else
    assign operand_a     = read_data1;
    assign operand_b_reg = read_data2;

    // The forwarding inputs stay on the port list so that both builds share
    // one interface. They are gathered here only so they do not dangle.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{rs1, rs2, wb_rd, wb_reg_write, wb_data};
`endif

    assign operand_b     = EX_ALU_Src ? imm : operand_b_reg;
    assign shamt         = operand_b[4:0];
    assign branch_target = pc_address + imm;

    // ALU control decode. Funct code 1000 means sub only for R-type
    // (EX_ALU_Src == 0). With an immediate it is an addi whose imm[10] bit
    // happens to be set. Unlisted codes fall back to add.
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (EX_ALU_Op)
            2'b01: alu_ctrl = ALU_SUB;
            2'b10: begin
                case (funct_inst_bits)
                    4'b0000: alu_ctrl = ALU_ADD;
                    4'b1000: alu_ctrl = EX_ALU_Src ? ALU_ADD : ALU_SUB;
                    4'b0111: alu_ctrl = ALU_AND;
                    4'b0110: alu_ctrl = ALU_OR;
                    4'b0100: alu_ctrl = ALU_XOR;
                    4'b0001: alu_ctrl = ALU_SLL;
                    4'b0101: alu_ctrl = ALU_SRL;
                    4'b1101: alu_ctrl = ALU_SRA;
                    4'b0010: alu_ctrl = ALU_SLT;
                    4'b0011: alu_ctrl = ALU_SLTU;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

    // ALU datapath. All arithmetic wraps. The set-less-than results are
    // a single bit zero-extended to the full width.
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            ALU_ADD:  alu_result = operand_a + operand_b;
            ALU_SUB:  alu_result = operand_a - operand_b;
            ALU_AND:  alu_result = operand_a & operand_b;
            ALU_OR:   alu_result = operand_a | operand_b;
            ALU_XOR:  alu_result = operand_a ^ operand_b;
            ALU_SLL:  alu_result = operand_a << shamt;
            ALU_SRL:  alu_result = operand_a >> shamt;
            ALU_SRA:  alu_result = $signed(operand_a) >>> shamt;
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, operand_a < operand_b};
            default:  alu_result = operand_a + operand_b;
        endcase
    end

    // EX/MEM register. Reset beats flush, and flush beats stall. A flush
    // still loads the computed data so that the only effect of the bubble is
    // that every control bit is cleared.
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_alu_result    <= '0;
            out_zero          <= 1'b0;
            out_write_data    <= '0;
            out_branch_target <= '0;
            out_rd            <= 5'd0;
            WB_reg_write_out  <= 1'b0;
            WB_mem_to_reg_out <= 1'b0;
            M_branch_out      <= 1'b0;
            M_mem_read_out    <= 1'b0;
            M_mem_write_out   <= 1'b0;
        end else if (flush || !stall) begin
            out_alu_result    <= alu_result;
            out_zero          <= (alu_result == '0);
            out_write_data    <= operand_b_reg;
            out_branch_target <= branch_target;
            out_rd            <= rd;
            WB_reg_write_out  <= flush ? 1'b0 : WB_reg_write;
            WB_mem_to_reg_out <= flush ? 1'b0 : WB_mem_to_reg;
            M_branch_out      <= flush ? 1'b0 : M_branch;
            M_mem_read_out    <= flush ? 1'b0 : M_mem_read;
            M_mem_write_out   <= flush ? 1'b0 : M_mem_write;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage
//
// Scoreboard bench for ex_mem_stage. Each applied cycle, a reference model
// computes the expected EX/MEM contents and pushes them onto a queue. After
// the clock edge the entry is popped and compared field by field against the
// DUT. The model keeps its own copy of the previous register contents so
// that it can handle stall, reset and forwarding. Build with +define+FWD_EN
// to exercise the forwarding variant.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage;

    typedef struct {
        logic [31:0] alu;
        logic        zero;
        logic [31:0] wdata;
        logic [31:0] target;
        logic [4:0]  rd;
        logic [4:0]  ctl;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] pc_address;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] imm;
    logic [3:0]  funct_inst_bits;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        WB_reg_write;
    logic        WB_mem_to_reg;
    logic        M_branch;
    logic        M_mem_read;
    logic        M_mem_write;
    logic [1:0]  EX_ALU_Op;
    logic        EX_ALU_Src;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic [31:0] out_alu_result;
    logic        out_zero;
    logic [31:0] out_write_data;
    logic [31:0] out_branch_target;
    logic [4:0]  out_rd;
    logic        WB_reg_write_out;
    logic        WB_mem_to_reg_out;
    logic        M_branch_out;
    logic        M_mem_read_out;
    logic        M_mem_write_out;

    exp_t sb[$];
    exp_t prev;
    int   total = 0;
    int   bad   = 0;

    ex_mem_stage #(.XLEN(32)) dut (
        .clock             (clock),
        .reset             (reset),
        .stall             (stall),
        .flush             (flush),
        .pc_address        (pc_address),
        .read_data1        (read_data1),
        .read_data2        (read_data2),
        .imm               (imm),
        .funct_inst_bits   (funct_inst_bits),
        .rd                (rd),
        .rs1               (rs1),
        .rs2               (rs2),
        .WB_reg_write      (WB_reg_write),
        .WB_mem_to_reg     (WB_mem_to_reg),
        .M_branch          (M_branch),
        .M_mem_read        (M_mem_read),
        .M_mem_write       (M_mem_write),
        .EX_ALU_Op         (EX_ALU_Op),
        .EX_ALU_Src        (EX_ALU_Src),
        .wb_rd             (wb_rd),
        .wb_reg_write      (wb_reg_write),
        .wb_data           (wb_data),
        .out_alu_result    (out_alu_result),
        .out_zero          (out_zero),
        .out_write_data    (out_write_data),
        .out_branch_target (out_branch_target),
        .out_rd            (out_rd),
        .WB_reg_write_out  (WB_reg_write_out),
        .WB_mem_to_reg_out (WB_mem_to_reg_out),
        .M_branch_out      (M_branch_out),
        .M_mem_read_out    (M_mem_read_out),
        .M_mem_write_out   (M_mem_write_out)
    );

    // Free-running clock with a 10-unit period
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference ALU, organised by operation rather than by control encoding
    function automatic logic [31:0] aluModel(input logic [1:0] op, input logic [3:0] fn,
                                             input logic src, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        if (op == 2'b01) return a - b;
        if (op != 2'b10) return a + b;
        case (fn)
            4'b1000: r = src ? a + b : a - b;
            4'b0111: r = a & b;
            4'b0110: r = a | b;
            4'b0100: r = a ^ b;
            4'b0001: r = a << b[4:0];
            4'b0101: r = a >> b[4:0];
            4'b1101: r = $signed(a) >>> b[4:0];
            4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: r = (a < b) ? 32'd1 : 32'd0;
            default: r = a + b;
        endcase
        return r;
    endfunction

    // Expected next register contents from the current inputs and model state
    function automatic exp_t computeExpected();
        exp_t        e;
        logic [31:0] a;
        logic [31:0] b;
        a = read_data1;
        b = read_data2;
`ifdef FWD_EN
        if (prev.ctl[4] && prev.rd != 5'd0 && prev.rd == rs1) a = prev.alu;
        else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs1) a = wb_data;
        if (prev.ctl[4] && prev.rd != 5'd0 && prev.rd == rs2) b = prev.alu;
        else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs2) b = wb_data;
`endif
        e.alu    = aluModel(EX_ALU_Op, funct_inst_bits, EX_ALU_Src, a, EX_ALU_Src ? imm : b);
        e.zero   = (e.alu == 32'd0);
        e.wdata  = b;
        e.target = pc_address + imm;
        e.rd     = rd;
        e.ctl    = {WB_reg_write, WB_mem_to_reg, M_branch, M_mem_read, M_mem_write};
        if (!reset) begin
            e = '{alu: 32'd0, zero: 1'b0, wdata: 32'd0, target: 32'd0, rd: 5'd0, ctl: 5'd0};
        end else if (flush) begin
            e.ctl = 5'd0;
        end else if (stall) begin
            e = prev;
        end
        return e;
    endfunction

    // Pops the oldest expectation and compares every output field
    task automatic collectOutput();
        exp_t e;
        e = sb.pop_front();
        checkOutput("alu_result", out_alu_result, e.alu);
        checkOutput("zero", {31'd0, out_zero}, {31'd0, e.zero});
        checkOutput("write_data", out_write_data, e.wdata);
        checkOutput("branch_target", out_branch_target, e.target);
        checkOutput("rd", {27'd0, out_rd}, {27'd0, e.rd});
        checkOutput("ctl", {27'd0, WB_reg_write_out, WB_mem_to_reg_out, M_branch_out,
                            M_mem_read_out, M_mem_write_out}, {27'd0, e.ctl});
    endtask

    // Pushes the expectation for the current inputs, clocks once, then checks
    task automatic applyStimulus();
        exp_t e;
        e = computeExpected();
        sb.push_back(e);
        prev = e;
        @(posedge clock);
        #1;
        collectOutput();
    endtask

    // Randomises all data and control inputs (reset/stall/flush set by caller)
    task automatic randInputs();
        pc_address      = $urandom;
        read_data1      = $urandom;
        read_data2      = ($urandom_range(0, 7) == 0) ? read_data1 : $urandom;
        imm             = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
        funct_inst_bits = 4'($urandom_range(0, 15));
        rd              = 5'($urandom_range(0, 7));
        rs1             = 5'($urandom_range(0, 7));
        rs2             = 5'($urandom_range(0, 7));
        WB_reg_write    = 1'($urandom_range(0, 1));
        WB_mem_to_reg   = 1'($urandom_range(0, 1));
        M_branch        = 1'($urandom_range(0, 1));
        M_mem_read      = 1'($urandom_range(0, 1));
        M_mem_write     = 1'($urandom_range(0, 1));
        EX_ALU_Op       = 2'($urandom_range(0, 3));
        EX_ALU_Src      = 1'($urandom_range(0, 1));
        wb_rd           = 5'($urandom_range(0, 7));
        wb_reg_write    = 1'($urandom_range(0, 1));
        wb_data         = $urandom;
    endtask

    // Quiet baseline: everything zero, out of reset, no stall or flush
    task automatic setIdle();
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        pc_address = 32'd0; read_data1 = 32'd0; read_data2 = 32'd0; imm = 32'd0;
        funct_inst_bits = 4'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        WB_reg_write = 1'b0; WB_mem_to_reg = 1'b0; M_branch = 1'b0;
        M_mem_read = 1'b0; M_mem_write = 1'b0; EX_ALU_Op = 2'b00; EX_ALU_Src = 1'b0;
        wb_rd = 5'd0; wb_reg_write = 1'b0; wb_data = 32'd0;
    endtask

    // Directed sequence followed by a constrained-random run
    initial begin
        prev = '{alu: 32'd0, zero: 1'b0, wdata: 32'd0, target: 32'd0, rd: 5'd0, ctl: 5'd0};

        // Reset held low with random inputs
        for (int i = 0; i < 2; i++) begin
            randInputs();
            reset = 1'b0; stall = 1'($urandom_range(0, 1)); flush = 1'($urandom_range(0, 1));
            applyStimulus();
        end
        checkOutput("reset_alu", out_alu_result, 32'd0);

        // sub 5 - 7, then the same funct with an immediate is an add
        setIdle();
        EX_ALU_Op = 2'b10; funct_inst_bits = 4'b1000; read_data1 = 32'd5; read_data2 = 32'd7;
        applyStimulus();
        checkOutput("sub_neg", out_alu_result, 32'hFFFF_FFFE);
        EX_ALU_Src = 1'b1; imm = 32'd7;
        applyStimulus();
        checkOutput("addi_1000", out_alu_result, 32'd12);

        // Equal operands for a branch compare
        setIdle();
        EX_ALU_Op = 2'b01; read_data1 = 32'h1234; read_data2 = 32'h1234;
        pc_address = 32'h100; imm = 32'hFFFF_FFF8; M_branch = 1'b1;
        applyStimulus();
        checkOutput("beq_zero", {31'd0, out_zero}, 32'd1);
        checkOutput("beq_target", out_branch_target, 32'hF8);
        checkOutput("beq_branch", {31'd0, M_branch_out}, 32'd1);

        // Arithmetic shift and the two set-less-than flavours
        setIdle();
        EX_ALU_Op = 2'b10; funct_inst_bits = 4'b1101; read_data1 = 32'h8000_0000;
        imm = 32'd4; EX_ALU_Src = 1'b1;
        applyStimulus();
        checkOutput("sra", out_alu_result, 32'hF800_0000);
        EX_ALU_Src = 1'b0; funct_inst_bits = 4'b0010; read_data1 = 32'hFFFF_FFFF; read_data2 = 32'd1;
        applyStimulus();
        checkOutput("slt", out_alu_result, 32'd1);
        funct_inst_bits = 4'b0011;
        applyStimulus();
        checkOutput("sltu", out_alu_result, 32'd0);

        // Load a valid op, stall three cycles, then stall and flush together
        setIdle();
        read_data1 = 32'd3; read_data2 = 32'd4; rd = 5'd9;
        WB_reg_write = 1'b1; WB_mem_to_reg = 1'b1; M_branch = 1'b1; M_mem_read = 1'b1; M_mem_write = 1'b1;
        applyStimulus();
        for (int i = 0; i < 3; i++) begin
            randInputs();
            reset = 1'b1; stall = 1'b1; flush = 1'b0;
            applyStimulus();
        end
        checkOutput("stall_hold", out_alu_result, 32'd7);
        randInputs();
        reset = 1'b1; stall = 1'b1; flush = 1'b1;
        applyStimulus();
        checkOutput("stall_flush_ctl", {27'd0, WB_reg_write_out, WB_mem_to_reg_out, M_branch_out,
                                        M_mem_read_out, M_mem_write_out}, 32'd0);

        // Forwarding: EX/MEM beats MEM/WB, x0 never forwarded, MEM/WB into B
        setIdle();
        rd = 5'd5; WB_reg_write = 1'b1; read_data1 = 32'd4; read_data2 = 32'd5;
        applyStimulus();
        setIdle();
        rs1 = 5'd5; read_data1 = 32'd100; EX_ALU_Src = 1'b1; rd = 5'd1;
        wb_rd = 5'd5; wb_reg_write = 1'b1; wb_data = 32'd3;
        applyStimulus();
`ifdef FWD_EN
        checkOutput("fwd_exmem", out_alu_result, 32'd9);
`else
        checkOutput("nofwd_a", out_alu_result, 32'd100);
`endif
        setIdle();
        rd = 5'd0; WB_reg_write = 1'b1; read_data1 = 32'd50;
        applyStimulus();
        setIdle();
        rs1 = 5'd0; read_data1 = 32'd77; wb_rd = 5'd0; wb_reg_write = 1'b1; wb_data = 32'd3;
        applyStimulus();
        checkOutput("x0_no_fwd", out_alu_result, 32'd77);
        setIdle();
        rs2 = 5'd6; read_data2 = 32'd11; read_data1 = 32'd1;
        wb_rd = 5'd6; wb_reg_write = 1'b1; wb_data = 32'd3;
        applyStimulus();
`ifdef FWD_EN
        checkOutput("fwd_memwb_b", out_write_data, 32'd3);
`else
        checkOutput("nofwd_b", out_write_data, 32'd11);
`endif

        // Random run with occasional reset, flush and stall
        for (int i = 0; i < 80; i++) begin
            randInputs();
            reset = ($urandom_range(0, 19) != 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 6) == 0);
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
